// File: rtl/lfu_pkg.sv
// Shared types and defaults for the LFU counter table and its aging logic.
// Holds the sweeper state encoding and the default table geometry.
package lfu_pkg;

   localparam int LFU_ENTRIES = 8;
   localparam int LFU_CNT_W   = 8;

   typedef logic [LFU_CNT_W-1:0] lfu_cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } age_state_t;

endpackage

// File: rtl/lfu_age_sweeper_tick_divider.sv
// Divides a qualified tick stream by AGE_TICKS, pulsing period on the wrap.
// The pulse is combinational on the tick that completes the period.
module tick_divider #(
   parameter int AGE_TICKS = 4
) (
   input  logic clock,
   input  logic rst,
   input  logic tick,
   input  logic enable,
   output logic period
);

   localparam int TC_W = $clog2(AGE_TICKS + 1);
   localparam logic [TC_W-1:0] LAST = TC_W'(AGE_TICKS - 1);

   logic [TC_W-1:0] cnt_q;
   logic [TC_W-1:0] cnt_d;
   logic            hit;

   // Advance on qualified ticks, wrap to zero on the last tick of a period.
   always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (tick && enable) begin
         if (cnt_q == LAST) begin
            hit   = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Tick counter register; holds its value while enable is low.
   always_ff @(posedge clock) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign period = hit;

endmodule

// File: rtl/lfu_age_sweeper.sv
// Periodic LFU aging: every AGE_TICKS ticks, halve each table entry.
// Optional LFU_AGE_OVERRUN_EN adds a sticky flag for dropped requests.
module lfu_age_sweeper
   import lfu_pkg::*;
#(
   parameter int ENTRIES   = LFU_ENTRIES,
   parameter int CNT_W     = LFU_CNT_W,
   parameter int AGE_TICKS = 4,
   parameter int IDX_W     = $clog2(ENTRIES)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             tick,
   input  logic             enable,
   output logic             rd_req,
   output logic [IDX_W-1:0] rd_idx,
   input  logic             rd_valid,
   input  logic [CNT_W-1:0] rd_data,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [CNT_W-1:0] wr_data,
   output logic             busy,
`ifdef LFU_AGE_OVERRUN_EN
   output logic             sweep_done,
   output logic             overrun
`else
   output logic             sweep_done
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   age_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cap_q, cap_d;
   logic             pend_q, pend_d;
   logic             req;

   logic             rd_req_q, rd_req_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             wr_en_q, wr_en_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0] wr_data_q, wr_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             drop;

   tick_divider #(
      .AGE_TICKS (AGE_TICKS)
   ) u_div (
      .clock  (clock),
      .rst    (rst),
      .tick   (tick),
      .enable (enable),
      .period (req)
   );

   // Sweep sequencing, pending-request bookkeeping and output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cap_d   = cap_q;
      pend_d  = pend_q;
      drop    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req || pend_q) begin
               state_d = READ;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         READ: begin
            if (req) begin
               if (pend_q) drop = 1'b1;
               else        pend_d = 1'b1;
            end
            if (rd_valid) begin
               cap_d   = rd_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (req) begin
               if (pend_q) drop = 1'b1;
               else        pend_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = READ;
            end
         end
         DONE: begin
            // A pending request restarts now; a fresh one
            // arriving alongside it takes the freed slot.
            if (pend_q) begin
               pend_d  = req;
               idx_d   = '0;
               state_d = READ;
            end else if (req) begin
               idx_d   = '0;
               state_d = READ;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rd_req_d  = (state_d == READ);
      rd_idx_d  = (state_d == READ) ? idx_d : '0;
      wr_en_d   = (state_d == WRITE);
      wr_idx_d  = (state_d == WRITE) ? idx_d : '0;
      wr_data_d = (state_d == WRITE) ? (cap_d >> 1) : '0;
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
   end

   // FSM state, sweep index, captured value and pending flag.
   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cap_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cap_q   <= cap_d;
         pend_q  <= pend_d;
      end
   end

   // Registered outputs, decoded from the next state.
   always_ff @(posedge clock) begin
      if (!rst) begin
         rd_req_q  <= 1'b0;
         rd_idx_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         rd_req_q  <= rd_req_d;
         rd_idx_q  <= rd_idx_d;
         wr_en_q   <= wr_en_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rd_req     = rd_req_q;
   assign rd_idx     = rd_idx_q;
   assign wr_en      = wr_en_q;
   assign wr_idx     = wr_idx_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign sweep_done = done_q;

`ifdef LFU_AGE_OVERRUN_EN
   logic ovr_q;

   // Sticky record of any request lost to a full pending slot.
   always_ff @(posedge clock) begin
      if (!rst)      ovr_q <= 1'b0;
      else if (drop) ovr_q <= 1'b1;
   end

   assign overrun = ovr_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_lfu_age_sweeper.sv
// Directed bench for lfu_age_sweeper: one AGE_TICKS=4 and one AGE_TICKS=1 DUT.
// A behavioural table answers reads with per-entry latency and logs writes.
module tb_lfu_age_sweeper;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b1;

   logic       tick = 1'b0;
   logic       rd_req, rd_valid = 1'b0;
   logic [2:0] rd_idx, wr_idx;
   logic [7:0] rd_data = 8'd0, wr_data;
   logic       wr_en, busy, done;

   logic       tick1 = 1'b0;
   logic       rd_req1, rd_valid1 = 1'b0;
   logic [2:0] rd_idx1, wr_idx1;
   logic [7:0] rd_data1 = 8'd0, wr_data1;
   logic       wr_en1, busy1, done1;
`ifdef LFU_AGE_OVERRUN_EN
   logic       ovr, ovr1;
`endif

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   lfu_age_sweeper #(.ENTRIES(8), .CNT_W(8), .AGE_TICKS(4)) u_a4 (
      .clock(clock), .rst(rst), .tick(tick), .enable(enable),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
      .rd_data(rd_data), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_data(wr_data), .busy(busy),
`ifdef LFU_AGE_OVERRUN_EN
      .sweep_done(done), .overrun(ovr)
`else
      .sweep_done(done)
`endif
   );

   lfu_age_sweeper #(.ENTRIES(8), .CNT_W(8), .AGE_TICKS(1)) u_a1 (
      .clock(clock), .rst(rst), .tick(tick1), .enable(enable),
      .rd_req(rd_req1), .rd_idx(rd_idx1), .rd_valid(rd_valid1),
      .rd_data(rd_data1), .wr_en(wr_en1), .wr_idx(wr_idx1),
      .wr_data(wr_data1), .busy(busy1),
`ifdef LFU_AGE_OVERRUN_EN
      .sweep_done(done1), .overrun(ovr1)
`else
      .sweep_done(done1)
`endif
   );

   logic [7:0] mem [8];
   int         lat [8];
   int         wait_cnt = 0;
   logic [2:0] hold_idx = 3'd0;
   int         stall_err = 0;
   int         zero_err = 0;
   int         done_cnt = 0;
   int         rd_seen = 0;
   int         busy_cyc = 0;
   logic [2:0] rlog [$];
   logic [2:0] wlog_i [$];
   logic [7:0] wlog_d [$];

   int         w1 = 0;
   int         d1 = 0;
   int         val1_err = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Table model for the AGE_TICKS=4 DUT with per-index read latency.
   always @(negedge clock) begin
      if (rd_valid) begin
         rd_valid = 1'b0;
         rd_data  = 8'd0;
         wait_cnt = 0;
      end else if (rd_req) begin
         if (wait_cnt == 0) begin
            hold_idx = rd_idx;
            rlog.push_back(rd_idx);
         end else if (rd_idx != hold_idx) begin
            stall_err++;
         end
         wait_cnt++;
         if (wait_cnt > lat[rd_idx]) begin
            rd_valid = 1'b1;
            rd_data  = mem[rd_idx];
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Write/strobe monitor for the AGE_TICKS=4 DUT.
   always @(negedge clock) begin
      if (wr_en) begin
         wlog_i.push_back(wr_idx);
         wlog_d.push_back(wr_data);
         mem[wr_idx] = wr_data;
      end else if (wr_idx != 3'd0 || wr_data != 8'd0) begin
         zero_err++;
      end
      if (!rd_req && rd_idx != 3'd0) zero_err++;
      if (done) done_cnt++;
      if (rd_req) rd_seen++;
      if (busy) busy_cyc++;
   end

   // Zero-latency table for the AGE_TICKS=1 DUT; entry i holds 2*i+1.
   always @(negedge clock) begin
      rd_valid1 = rd_req1;
      rd_data1  = {4'd0, rd_idx1, 1'b1};
      if (wr_en1) begin
         w1++;
         if (wr_data1 != {5'd0, wr_idx1}) val1_err++;
      end
      if (done1) d1++;
   end

   task automatic preload();
      logic [7:0] init [8];
      init = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd100, 8'd127, 8'd254, 8'd255};
      for (int i = 0; i < 8; i++) begin
         mem[i] = init[i];
         lat[i] = 2;
      end
   endtask

   task automatic clear_logs();
      rlog.delete();
      wlog_i.delete();
      wlog_d.delete();
      done_cnt = 0;
      rd_seen  = 0;
      busy_cyc = 0;
   endtask

   task automatic pulse(input int which);
      @(negedge clock);
      if (which == 1) tick1 = 1'b1;
      else            tick  = 1'b1;
      @(negedge clock);
      tick1 = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic ticks4(input int n);
      for (int i = 0; i < n; i++) pulse(0);
   endtask

   task automatic wait_idle(string tag, input int which, input int budget);
      int n;
      n = 0;
      while (((which == 1) ? busy1 : busy) != 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      while (((which == 1) ? busy1 : busy) != 1'b0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (n >= budget) check({tag, "_timeout"}, 1, 0);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      logic [7:0] exp1 [8];
      logic [7:0] exp2 [8];
      int n;
      exp1 = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd50, 8'd63, 8'd127, 8'd127};
      exp2 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd50, 8'd63, 8'd127, 8'd127};
      preload();

      rst = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_rd_req", rd_req, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_busy1", busy1, 0);
`ifdef LFU_AGE_OVERRUN_EN
      check("rst_ovr", ovr, 0);
`endif
      @(negedge clock);
      rst = 1'b1;
      clear_logs();
      repeat (100) @(negedge clock);
      check("idle_rd_seen", rd_seen, 0);
      check("idle_busy", busy_cyc, 0);

      clear_logs();
      ticks4(3);
      repeat (5) @(negedge clock);
      check("three_ticks_idle", busy_cyc, 0);
      ticks4(1);
      wait_idle("basic", 0, 400);
      check("basic_nwr", wlog_i.size(), 8);
      for (int i = 0; i < 8 && i < wlog_i.size(); i++) begin
         check($sformatf("basic_idx%0d", i), wlog_i[i], i);
         check($sformatf("basic_dat%0d", i), wlog_d[i], exp1[i]);
      end
      check("basic_done", done_cnt, 1);
      check("basic_busy_end", busy, 0);

      preload();
      lat[3] = 10;
      clear_logs();
      stall_err = 0;
      ticks4(4);
      wait_idle("stall", 0, 400);
      check("stall_stable", stall_err, 0);
      check("stall_nwr", wlog_i.size(), 8);
      check("stall_nrd", rlog.size(), 8);
      for (int i = 0; i < 8 && i < wlog_i.size(); i++)
         check($sformatf("stall_idx%0d", i), wlog_i[i], i);
      check("stall_done", done_cnt, 1);

      preload();
      clear_logs();
      enable = 1'b0;
      ticks4(10);
      repeat (10) @(negedge clock);
      check("gate_off_busy", busy_cyc, 0);
      enable = 1'b1;
      ticks4(3);
      repeat (10) @(negedge clock);
      check("gate_held_cnt", busy_cyc, 0);
      ticks4(1);
      wait_idle("gate", 0, 400);
      check("gate_done", done_cnt, 1);
      check("gate_nwr", wlog_i.size(), 8);

      preload();
      clear_logs();
      ticks4(4);
      n = 0;
      while (!(wr_en && wr_idx == 3'd2) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("mid_timeout", 1, 0);
      rst = 1'b0;
      @(posedge clock);
      #1;
      check("mid_wr_en", wr_en, 0);
      check("mid_busy", busy, 0);
      check("mid_rd_req", rd_req, 0);
      @(negedge clock);
      rst = 1'b1;
      repeat (20) @(negedge clock);
      check("mid_nwr", wlog_i.size(), 3);
      check("mid_mem2", mem[2], 1);
      check("mid_mem3", mem[3], 3);
      check("mid_mem7", mem[7], 255);
      clear_logs();
      ticks4(4);
      wait_idle("restart", 0, 400);
      check("restart_nrd", rlog.size(), 8);
      if (rlog.size() > 0) check("restart_first", rlog[0], 0);
      for (int i = 0; i < 8 && i < wlog_d.size(); i++)
         check($sformatf("restart_dat%0d", i), wlog_d[i], exp2[i]);
      check("strobe_zero", zero_err, 0);

      w1 = 0;
      d1 = 0;
      pulse(1);
      repeat (3) @(negedge clock);
      pulse(1);
      wait_idle("b2b", 1, 200);
      check("b2b_done", d1, 2);
      check("b2b_nwr", w1, 16);
`ifdef LFU_AGE_OVERRUN_EN
      check("b2b_ovr", ovr1, 0);
`endif

      w1 = 0;
      d1 = 0;
      pulse(1);
      repeat (2) @(negedge clock);
      pulse(1);
      pulse(1);
      pulse(1);
      wait_idle("ovr", 1, 200);
      check("ovr_done", d1, 2);
      check("ovr_nwr", w1, 16);
`ifdef LFU_AGE_OVERRUN_EN
      check("ovr_flag", ovr1, 1);
      check("ovr_other", ovr, 0);
`endif
      check("a1_values", val1_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lfu_age_sweeper.md
Name: lfu_age_sweeper

Overview:
Consumer end of the periodic tick interface. Counts one-cycle tick pulses from the design's tick generator. Every AGE_TICKS ticks it sweeps the LFU frequency-counter table and halves every entry, so stale usage counts decay. Sits between the tick generator and the LFU counter table's arbitrated read/write port.

Parameters:
ENTRIES, 8, number of frequency-counter entries (>= 2)
CNT_W, 8, width of each frequency counter
AGE_TICKS, 4, ticks per aging sweep (>= 1)
IDX_W, $clog2(ENTRIES), derived index width; not overridden

Ports:
clock  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-low
tick  input  1  one-cycle pulse from the tick generator
enable  input  1  1 = count ticks; 0 = tick counting frozen
rd_req  output  1  read request to counter table
rd_idx  output  IDX_W  entry being read
rd_valid  input  1  table read data valid (ends the read handshake)
rd_data  input  CNT_W  counter value, valid when rd_valid=1
wr_en  output  1  one-cycle write strobe
wr_idx  output  IDX_W  entry being written
wr_data  output  CNT_W  aged value
busy  output  1  sweep in progress
sweep_done  output  1  one-cycle pulse after the last entry is written

Behaviour:
- Reset (rst=0 at a posedge) sets all outputs to 0, tick_cnt=0, pending=0, idx=0 and the FSM to IDLE. Reset mid-sweep abandons the sweep immediately, with no further writes.
- tick_cnt (width $clog2(AGE_TICKS+1)) increments on tick=1 && enable=1, in every state. When tick_cnt==AGE_TICKS-1 and a qualifying tick arrives, tick_cnt wraps to 0 and a sweep request is raised. With AGE_TICKS=1, every tick is a request.
- Sweep request in IDLE: the FSM goes to READ on the next cycle.
- Sweep request while busy: sets pending. If pending is already set, the new request is dropped.
- FSM states are IDLE, READ, WRITE, DONE.
  - IDLE: busy=0. Moves to READ when a request or pending is set. Clears pending and sets idx=0.
  - READ: busy=1, rd_req=1, rd_idx=idx. rd_req and rd_idx stay stable until rd_valid=1. rd_valid is ignored in all states except READ. On rd_valid, rd_data is captured and the FSM moves to WRITE.
  - WRITE: wr_en=1 for exactly one cycle, wr_idx=idx, wr_data = captured >> 1 (floor; 0->0, 1->0, max->max>>1). If idx==ENTRIES-1 go to DONE; else idx+1 and go to READ.
  - DONE: sweep_done=1 for one cycle, busy=1. If pending is set, clear it, set idx=0 and go to READ; else go to IDLE.
- Per-entry cost is read latency + 1 cycle. rd_req drops in the WRITE cycle, so there is a minimum one-cycle gap between reads.
- enable=0 only freezes tick_cnt (value held). An in-flight sweep always completes. A pending request is still serviced.
- A tick coincident with DONE and pending=0 is counted normally. If that tick completes a period, the FSM goes straight from DONE to READ.
- Outputs are registered. wr_data, wr_idx and rd_idx are 0 whenever their strobe is low.

Optional Feature:
LFU_AGE_OVERRUN_EN
- Defined: adds output overrun (1 bit, reset 0). It is a sticky flag set when a sweep request is dropped because pending was already set. It is cleared only by reset.
- Undefined: port absent. Dropped requests are silent; all other behaviour is identical.

Decomposition:
- Shared package lfu_pkg holds:
  - state enum age_state_t {IDLE, READ, WRITE, DONE}
  - default constants LFU_ENTRIES=8 and LFU_CNT_W=8
  - counter typedef lfu_cnt_t = logic [LFU_CNT_W-1:0]
- Natural sub-module tick_divider: counts qualified ticks and emits a one-cycle period pulse every AGE_TICKS ticks, reusable elsewhere. The FSM and handshake stay in lfu_age_sweeper.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then 1, no ticks -> all outputs 0, no rd_req for 100 cycles.
- Basic sweep: ENTRIES=8, AGE_TICKS=4, table preloaded {0,1,2,3,100,127,254,255}, rd_valid 2 cycles after rd_req, 4 ticks -> writes idx 0..7 in order with {0,0,1,1,50,63,127,127}, then one sweep_done pulse, then busy=0.
- Handshake stall: rd_valid delayed 10 cycles on idx 3 -> rd_req and rd_idx=3 held stable the whole time; exactly 8 wr_en pulses; no duplicate or skipped index.
- Pending/back-to-back: AGE_TICKS=1, a tick during the sweep -> DONE goes directly to READ idx 0; a second sweep runs, giving 2 sweep_done pulses in total. Three ticks during one sweep -> still only one extra sweep, and overrun=1 with LFU_AGE_OVERRUN_EN.
- Enable gating: enable=0 during 10 ticks -> no sweep and tick_cnt held. Then enable=1 with 4 ticks -> one sweep.
- Reset mid-sweep: rst=0 while in WRITE for idx 2 -> next cycle wr_en=0, busy=0, idx=0. Entries 3..7 are left unmodified, and a subsequent sweep starts from idx 0.
